// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux select sequencer.
//   scan_state_t : FSM encoding (IDLE / DWELL / DONE)
//   NUM_CH, CH_W : mux channel count and select width
//   DWELL_MIN/MAX: legal dwell range, dwell_ok() range check
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_t;

  localparam int NUM_CH    = 4;
  localparam int CH_W      = 2;
  localparam int DWELL_MIN = 1;
  localparam int DWELL_MAX = 255;

  function automatic bit dwell_ok(input int d);
    return (d >= DWELL_MIN) && (d <= DWELL_MAX);
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Word delivery bundle of the mux select sequencer.
//   data  : 4-bit assembled word, bit k = mux output while channel k selected
//   valid : data holds a word not yet consumed
//   ready : consumer accepts
// Handshake: a word transfers on any rising edge where valid & ready are both
// high. Once valid is high, data is held stable until that transfer; the
// producer never retracts valid. ready may be driven freely by the consumer.
interface mux_scan_ctrl_if;
  logic [3:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mux_4_1.sv
// 4:1 single-bit multiplexer driven by the scan sequencer.
//   i_0..i_3 : data inputs
//   s_1,s_0  : select, {s_1,s_0}=k routes i_k to y
//   y        : selected input (combinational)
module mux_4_1 (
  input  logic i_0,
  input  logic i_1,
  input  logic i_2,
  input  logic i_3,
  input  logic s_0,
  input  logic s_1,
  output logic y
);
  assign y = s_1 ? (s_0 ? i_3 : i_2) : (s_0 ? i_1 : i_0);
endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin select sequencer for a 4:1 single-bit mux.
// Steps the mux selects through channels 0..3, holds each for DWELL cycles,
// samples y on the last dwell cycle of each channel and delivers the four
// samples as one word over a valid/ready bundle, flagging dropped words.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : scan request, only looked at in IDLE
//   cont       : continuous mode, looked at on each channel-3 sample edge
//   y          : mux output
//   s_0, s_1   : registered mux selects
//   busy       : scan in progress
//   overrun    : sticky, a completed word was dropped; cleared by next start
//   dbg_state  : current FSM state
//   bus        : data/valid/ready word delivery (master side)
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CW    = $clog2(DWELL + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    y,
  output logic                    s_0,
  output logic                    s_1,
  output logic                    busy,
  output logic                    overrun,
  output scan_state_t             dbg_state,
  mux_scan_ctrl_if.master         bus
);

  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  scan_state_t       state_q, state_n;
  logic [CH_W-1:0]   ch_q, ch_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [NUM_CH-1:0] smp_q, smp_n;
  logic [3:0]        data_q, data_n;
  logic              valid_q, valid_n;
  logic              ovr_q, ovr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      smp_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      ch_q    <= ch_n;
      cnt_q   <= cnt_n;
      smp_q   <= smp_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ovr_q   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    ch_n    = ch_q;
    cnt_n   = cnt_q;
    smp_n   = smp_q;
    data_n  = data_q;
    valid_n = valid_q;
    ovr_n   = ovr_q;

    // Consumption; a word loaded on the same edge overrides this below.
    if (valid_q && bus.ready) valid_n = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ch_n  = '0;
        cnt_n = '0;
        if (start) begin
          state_n = ST_DWELL;
          smp_n   = '0;
          ovr_n   = 1'b0;
        end
      end

      ST_DWELL: begin
        if (cnt_q == LAST_CNT) begin
          cnt_n     = '0;
          smp_n[ch_q] = y;
          if (ch_q != LAST_CH) begin
            ch_n = ch_q + CH_W'(1);
          end else begin
            // Word completion: the channel-3 sample goes straight into the
            // word, so the DONE step is resolved within this edge.
            if (!valid_q || bus.ready) begin
              data_n  = {y, smp_q[2:0]};
              valid_n = 1'b1;
            end else begin
              ovr_n = 1'b1;
            end
            ch_n    = '0;
            smp_n   = '0;
            state_n = cont ? ST_DWELL : ST_IDLE;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end

      // Completion never parks the register in DONE; recover to IDLE.
      default: begin
        state_n = ST_IDLE;
        ch_n    = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // Selects come straight from the channel register: no decode glitches.
  assign s_0       = ch_q[0];
  assign s_1       = ch_q[1];
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = ovr_q;
  assign dbg_state = state_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;

  dwell_range_a: assert property (@(posedge clk) dwell_ok(DWELL));

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  // ---------------- DUT A: DWELL=2 ----------------
  logic        start_a, cont_a, y_a, s0_a, s1_a, busy_a, ovr_a;
  logic [3:0]  i_a;
  scan_state_t state_a;
  mux_scan_ctrl_if bus_a();

  mux_scan_ctrl #(.DWELL(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cont(cont_a), .y(y_a),
    .s_0(s0_a), .s_1(s1_a), .busy(busy_a), .overrun(ovr_a),
    .dbg_state(state_a), .bus(bus_a.master)
  );
  mux_4_1 u_mux_a (
    .i_0(i_a[0]), .i_1(i_a[1]), .i_2(i_a[2]), .i_3(i_a[3]),
    .s_0(s0_a), .s_1(s1_a), .y(y_a)
  );

  // ---------------- DUT B: DWELL=1 ----------------
  logic        start_b, cont_b, y_b, s0_b, s1_b, busy_b, ovr_b;
  logic [3:0]  i_b;
  scan_state_t state_b;
  mux_scan_ctrl_if bus_b();

  mux_scan_ctrl #(.DWELL(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont(cont_b), .y(y_b),
    .s_0(s0_b), .s_1(s1_b), .busy(busy_b), .overrun(ovr_b),
    .dbg_state(state_b), .bus(bus_b.master)
  );
  mux_4_1 u_mux_b (
    .i_0(i_b[0]), .i_1(i_b[1]), .i_2(i_b[2]), .i_3(i_b[3]),
    .s_0(s0_b), .s_1(s1_b), .y(y_b)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sel_a();
    return {6'd0, s1_a, s0_a};
  endfunction

  function automatic logic [7:0] sel_b();
    return {6'd0, s1_b, s0_b};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- scoreboard (streaming) ----------------
  logic [3:0] exp_q[$];
  bit         sb_en = 1'b0;
  int         last_pop = -1;

  always @(negedge clk) begin
    if (sb_en && bus_a.valid && bus_a.ready) begin
      if (exp_q.size() == 0) begin
        chk("stream_unexpected_word", {4'd0, bus_a.data}, 8'hff);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("stream_data", {4'd0, bus_a.data}, {4'd0, e});
        if (last_pop >= 0) chk("stream_spacing", 8'(cycle - last_pop), 8'd8);
        last_pop = cycle;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] i;     // i[k] drives mux input i_k
    logic [3:0] exp;   // expected word
    bit         poke;  // pulse start during the scan
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; cont_a = 1'b0; i_a = 4'd0; bus_a.ready = 1'b0;
    start_b = 1'b0; cont_b = 1'b0; i_b = 4'd0; bus_b.ready = 1'b0;

    // i_0..i_3 = 1,0,1,1 -> 1101 ; with pokes: start pulses mid-scan
    vecs[0] = '{i: 4'b1101, exp: 4'b1101, poke: 1'b0};
    vecs[1] = '{i: 4'b0000, exp: 4'b0000, poke: 1'b0};
    vecs[2] = '{i: 4'b1111, exp: 4'b1111, poke: 1'b1};
    vecs[3] = '{i: 4'b1000, exp: 4'b1000, poke: 1'b0};
    vecs[4] = '{i: 4'b0101, exp: 4'b0101, poke: 1'b1};

    // ---- reset state ----
    steps(2);
    chk("rst_sel",     sel_a(), 8'd0);
    chk("rst_valid",   {7'd0, bus_a.valid}, 8'd0);
    chk("rst_busy",    {7'd0, busy_a}, 8'd0);
    chk("rst_data",    {4'd0, bus_a.data}, 8'd0);
    chk("rst_overrun", {7'd0, ovr_a}, 8'd0);
    chk("rst_state",   8'(state_a), 8'(ST_IDLE));
    rst_n = 1'b1;
    steps(2);
    chk("idle_no_start_busy", {7'd0, busy_a}, 8'd0);

    // ---- single-shot scans from the table ----
    for (int v = 0; v < 5; v++) begin
      i_a = vecs[v].i;
      cont_a = 1'b0;
      bus_a.ready = 1'b1;
      start_a = 1'b1;
      step();                       // edge E0
      start_a = 1'b0;
      chk("ss_busy_e0", {7'd0, busy_a}, 8'd1);
      chk("ss_sel_e0", sel_a(), 8'd0);
      for (int k = 1; k <= 8; k++) begin
        start_a = (vecs[v].poke && (k % 3 == 0)) ? 1'b1 : 1'b0;
        step();                     // edge E0+k
        start_a = 1'b0;
        if (k < 8) begin
          chk("ss_sel", sel_a(), 8'(k / 2));
          chk("ss_valid_early", {7'd0, bus_a.valid}, 8'd0);
          chk("ss_busy", {7'd0, busy_a}, 8'd1);
        end else begin
          chk("ss_valid", {7'd0, bus_a.valid}, 8'd1);
          chk("ss_data", {4'd0, bus_a.data}, {4'd0, vecs[v].exp});
          chk("ss_busy_done", {7'd0, busy_a}, 8'd0);
          chk("ss_sel_done", sel_a(), 8'd0);
        end
      end
      step();
      chk("ss_valid_consumed", {7'd0, bus_a.valid}, 8'd0);
      chk("ss_data_hold", {4'd0, bus_a.data}, {4'd0, vecs[v].exp});
    end

    // ---- continuous streaming, ready=1 ----
    sb_en = 1'b1;
    last_pop = -1;
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b1000);
    i_a = 4'b1111; cont_a = 1'b1; bus_a.ready = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    steps(8);                       // E0+8: first word, wrap to channel 0
    chk("st_valid1", {7'd0, bus_a.valid}, 8'd1);
    chk("st_busy_wrap", {7'd0, busy_a}, 8'd1);
    chk("st_sel_wrap", sel_a(), 8'd0);
    i_a = 4'b1000;                  // i_3=1 only
    cont_a = 1'b0;
    step();                         // E0+9
    chk("st_valid_drop", {7'd0, bus_a.valid}, 8'd0);
    chk("st_sel_ch0", sel_a(), 8'd0);
    step();                         // E0+10
    chk("st_sel_ch1", sel_a(), 8'd1);
    steps(6);                       // E0+16: second word
    chk("st_valid2", {7'd0, bus_a.valid}, 8'd1);
    chk("st_busy_end", {7'd0, busy_a}, 8'd0);
    step();
    sb_en = 1'b0;
    chk("st_queue_empty", 8'(exp_q.size()), 8'd0);

    // ---- backpressure / overrun ----
    i_a = 4'b0110; cont_a = 1'b1; bus_a.ready = 1'b0;
    start_a = 1'b1;
    step();                         // E0
    start_a = 1'b0;
    steps(8);                       // E0+8
    chk("bp_valid1", {7'd0, bus_a.valid}, 8'd1);
    chk("bp_data1", {4'd0, bus_a.data}, 8'h06);
    chk("bp_ovr0", {7'd0, ovr_a}, 8'd0);
    i_a = 4'b1111;
    steps(8);                       // E0+16: word dropped
    chk("bp_ovr1", {7'd0, ovr_a}, 8'd1);
    chk("bp_data_kept", {4'd0, bus_a.data}, 8'h06);
    chk("bp_valid_kept", {7'd0, bus_a.valid}, 8'd1);
    cont_a = 1'b0;
    bus_a.ready = 1'b1;
    step();                         // E0+17: consume
    bus_a.ready = 1'b0;
    chk("bp_consumed", {7'd0, bus_a.valid}, 8'd0);
    chk("bp_data_after", {4'd0, bus_a.data}, 8'h06);
    steps(7);                       // E0+24: third scan lands, then idle
    chk("bp_valid3", {7'd0, bus_a.valid}, 8'd1);
    chk("bp_data3", {4'd0, bus_a.data}, 8'h0f);
    chk("bp_busy3", {7'd0, busy_a}, 8'd0);
    chk("bp_ovr_sticky", {7'd0, ovr_a}, 8'd1);
    bus_a.ready = 1'b1;
    step();
    chk("bp_valid3_consumed", {7'd0, bus_a.valid}, 8'd0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("bp_ovr_cleared", {7'd0, ovr_a}, 8'd0);
    steps(8);
    chk("bp_last_valid", {7'd0, bus_a.valid}, 8'd1);
    step();

    // ---- reset mid-scan ----
    i_a = 4'b1010; cont_a = 1'b0; bus_a.ready = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    steps(8);
    chk("rm_valid_pre", {7'd0, bus_a.valid}, 8'd1);
    chk("rm_data_pre", {4'd0, bus_a.data}, 8'h0a);
    start_a = 1'b1;
    step();                         // E1
    start_a = 1'b0;
    steps(5);                       // inside channel 2 dwell
    chk("rm_sel_ch2", sel_a(), 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_sel", sel_a(), 8'd0);
    chk("rm_valid", {7'd0, bus_a.valid}, 8'd0);
    chk("rm_busy", {7'd0, busy_a}, 8'd0);
    chk("rm_data", {4'd0, bus_a.data}, 8'd0);
    chk("rm_state", 8'(state_a), 8'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    steps(3);
    chk("rm_idle_busy", {7'd0, busy_a}, 8'd0);
    chk("rm_idle_sel", sel_a(), 8'd0);
    chk("rm_idle_valid", {7'd0, bus_a.valid}, 8'd0);

    // ---- DWELL=1: i_0..i_3 = 1,1,0,0 -> 0011 ----
    i_b = 4'b0011; cont_b = 1'b0; bus_b.ready = 1'b1;
    start_b = 1'b1;
    step();                         // E0
    start_b = 1'b0;
    chk("d1_busy", {7'd0, busy_b}, 8'd1);
    chk("d1_sel0", sel_b(), 8'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("d1_sel", sel_b(), 8'(k));
      chk("d1_valid_early", {7'd0, bus_b.valid}, 8'd0);
    end
    step();                         // E0+4
    chk("d1_valid", {7'd0, bus_b.valid}, 8'd1);
    chk("d1_data", {4'd0, bus_b.data}, 8'h03);
    chk("d1_busy_done", {7'd0, busy_b}, 8'd0);
    chk("d1_sel_done", sel_b(), 8'd0);
    step();
    chk("d1_consumed", {7'd0, bus_b.valid}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Round-robin select sequencer that sits directly upstream of the 4:1 single-bit mux (mux_4_1).
- Drives the mux selects s_1/s_0 through channels 0..3.
- Holds each channel for a programmable dwell time and samples the mux output y on the last dwell cycle.
- Assembles the four samples into a 4-bit word, delivered over a valid/ready handshake with overrun detection.
- Supports single-shot and continuous scan modes.

Parameters:
- DWELL, 2, cycles each channel is selected before y is sampled; legal range 1..255.
- CW, $clog2(DWELL+1), dwell counter width; derived, do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at every channel-3 sample edge.
- y  input  1  mux output (combinational from mux_4_1).
- s_0  output  1  mux select LSB.
- s_1  output  1  mux select MSB.
- data  output  4  assembled word; data[k] = y sampled while {s_1,s_0}==k.
- valid  output  1  data holds an unconsumed word.
- ready  input  1  consumer accepts data when valid&ready.
- busy  output  1  scan in progress (state != IDLE).
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; {s_1,s_0}=00; data=0; valid=0; busy=0; overrun=0; dwell count=0; sample shift register=0.
  - Reset mid-scan aborts immediately; the partial word is discarded.
- FSM states: IDLE, DWELL, DONE.
- IDLE:
  - Selects held at 00.
  - start=1 at edge E0 -> DWELL, channel=0, count=0, busy=1; overrun cleared at this edge.
- DWELL:
  - count increments each edge.
  - When count==DWELL-1, the edge samples y into sample bit [channel] and resets count.
  - If channel<3 on that edge: channel+1, and {s_1,s_0} changes on the same edge.
  - If channel==3: go to DONE handling on the same edge (below).
  - y is sampled at edges E0+DWELL, E0+2*DWELL, E0+3*DWELL, E0+4*DWELL.
  - start is ignored while busy.
- Word completion, channel-3 sample edge:
  - If valid==0 or ready==1 that cycle: data <= assembled word (current y merged into bit 3), valid=1.
  - Otherwise the word is dropped, data is unchanged and overrun<=1.
  - Next state: if cont=1, DWELL with channel=0 and selects=00 (no idle gap); else IDLE with busy=0.
  - Latency, single-shot: valid rises at edge E0+4*DWELL, i.e. 8 cycles for DWELL=2.
- Handshake:
  - valid&ready with no simultaneous load -> valid<=0; data holds its value.
  - Simultaneous consume and load -> valid stays 1 with the new data.
  - data is stable while valid=1 and ready=0.
- cont deasserted mid-scan: the current scan completes, then IDLE.
- DWELL=1: selects advance every edge; every cycle is a sample cycle.
- Select outputs are registered directly from the channel register (glitch-free).

Decomposition:
- Package mux_scan_pkg holds:
  - state enum (IDLE, DWELL, DONE);
  - NUM_CH=4 and CH_W=2 constants;
  - the DWELL range-check constants.
- No sub-module required. The dwell counter is inline.
- The bench instantiates mux_4_1 downstream of the selects and closes the y loop through it.

Test Plan:
- Single-shot: DWELL=2, mux i_0..i_3=1,0,1,1, ready=1, pulse start -> selects step 00,01,10,11 every 2 cycles; valid rises 8 cycles after start with data=4'b1101; busy returns 0 on the same edge.
- Backpressure/overrun: cont=1, ready=0, i=0,1,1,0 -> first word data=4'b0110, valid=1; second completion sets overrun=1 and data stays 0110. ready=1 for one cycle -> valid=0. Next start from IDLE clears overrun.
- Continuous streaming: cont=1, ready=1, inputs changed between scans (1111 then 0001) -> back-to-back words 4'b1111, 4'b1000 spaced 4*DWELL cycles apart; selects wrap 11->00 with no gap.
- Reset mid-scan: assert rst_n=0 during channel 2 dwell -> selects, valid, busy and data go to 0 immediately without a clock. After release, idle until start.
- start ignored while busy, and DWELL=1: start pulses during a scan do not restart it (selects sequence unchanged). Rebuild with DWELL=1: valid 4 cycles after start, with correct data for i=1,1,0,0 -> 4'b0011.
